sound_mixer: RTL
================

# sound_mixer

Time-multiplexed digital mixer that sits directly upstream of `i2s_audio`. It combines up to eight signed 16-bit source channels (PSG, SCC, OPLL and similar) into the single signed 16-bit `sound_in` word that `i2s_audio` serialises. Each channel has a per-channel 8-bit volume. The mixer runs off the 42.95454 MHz system clock and produces one mixed sample per programmable sample period, using a single shared multiplier.

## Interface
- `CHANNELS`, default 4: number of source channels, 1..8.
- `DIV`, default 896: system clocks per output sample (≈47.94 kHz at 42.95454 MHz); must be ≥ CHANNELS+3.

- `clk`, in, 1: system clock, 42.95454 MHz.
- `reset`, in, 1: asynchronous, active-high reset.
- `ch_in`, in, CHANNELS*16: signed 16-bit channel samples; channel i occupies bits [16i+15:16i].
- `vol_wr`, in, 1: one-cycle volume write strobe.
- `vol_addr`, in, 3: channel index for the write.
- `vol_data`, in, 8: unsigned volume; 128 means unity gain.
- `sound_out`, out, 16: signed mixed sample; connects to `i2s_audio.sound_in`.
- `sound_valid`, out, 1: one-cycle pulse when `sound_out` updates.

## Operation
- Tick counter `cnt` counts 0..DIV-1 and wraps. Tick occurs in the cycle where `cnt == DIV-1`.
- Volume registers `vol[i]` reset to 128.
  - A write with `vol_wr=1` and `vol_addr < CHANNELS` updates `vol[vol_addr]` at the clock edge.
  - A write with `vol_addr ≥ CHANNELS` is ignored.
- FSM states and transitions:
  - IDLE → MAC on tick. At that edge, all `ch_in` and all `vol` are copied into snapshot registers, `acc` is cleared, and `idx` is set to 0.
  - MAC: one channel per cycle, `acc += snap_ch[idx] * snap_vol[idx]`, `idx++`. Goes to SAT after `idx == CHANNELS-1`.
  - SAT: computes `s = acc >>> 7` (arithmetic shift; truncation toward −∞). Clamps `s` to [−32768, 32767] and registers the result into `sound_out`. Pulses `sound_valid`. Then returns to IDLE.
- Arithmetic widths:
  - Product: signed 16 × unsigned 8, computed as signed 17×9, giving a 24-bit signed result.
  - `acc`: 27-bit signed, which holds 8 full-scale products without overflow.
- Simultaneous events:
  - A volume write in the tick cycle itself does not reach the snapshot; it applies from the next sample.
  - A volume write during MAC or SAT does not affect the sample in progress.
- `sound_out` holds its value between `sound_valid` pulses. Downstream may sample it at any time.
- Reset, including reset asserted mid-MAC: everything returns to reset values immediately. The partial sample is discarded and no `sound_valid` pulse is issued for it.

## Timing
- Reset values:
  - `cnt` = 0, state = IDLE, `acc` = 0, `idx` = 0.
  - `vol[*]` = 128, snapshots = 0.
  - `sound_out` = 0, `sound_valid` = 0.
- The first tick is at `cnt == DIV-1`, i.e. the DIV-th cycle after reset release.
- Latency: tick edge E. MAC occupies edges E+1..E+CHANNELS. `sound_out` and `sound_valid` are valid after edge E+CHANNELS+1. For CHANNELS=4 that is 5 clocks after the tick edge.
- `sound_valid` period is exactly DIV clocks, and it is high for exactly one clock.
- `ch_in` needs to be stable only in the tick cycle.

## Structure
- Package `sound_mixer_pkg` contains:
  - Constants: `SAMPLE_W=16`, `VOL_W=8`, `ACC_W=27`, `VOL_UNITY=128`, `GAIN_SHIFT=7`.
  - Typedef: `mixer_state_t` enum {IDLE, MAC, SAT}.
- One sub-module, `sample_tick_gen`, holds the DIV counter and emits the one-cycle `tick`; it is parameterised by DIV.
- Saturation is inline combinational logic in the SAT state.

## Test plan
- Reset and idle: hold `reset`, then release with `ch_in=0`.
  - During reset: `sound_out=0`, `sound_valid=0`.
  - First `sound_valid` arrives DIV+5 clocks after release, with `sound_out=0`.
- Unity gain: `ch0=16'h1000`, other channels 0, default volumes → `sound_out=16'h1000`. Successive `sound_valid` pulses are exactly 896 clocks apart.
- Sum: all four channels `16'h1000` → `16'h4000`. Channels {`16'h1000`, `16'hF000`, 0, 0} → `16'h0000`.
- Saturation:
  - All channels `16'h7FFF` → `16'h7FFF`.
  - All channels `16'h8000` → `16'h8000`.
  - Single channel `16'h7FFF` with `vol=255` → `16'h7FFF`.
- Volume:
  - Write `vol[1]=64` with `ch1=16'h2000` → `16'h1000`.
  - Write `vol[5]=0` (out of range) → no effect.
  - A write issued during MAC leaves the current sample unchanged and applies to the next one.
- Mid-operation reset: assert `reset` two cycles after a tick with `ch0=16'h1000`.
  - No `sound_valid` pulse for that sample.
  - `sound_out=0` and `vol[*]=128` after reset.
  - Next `sound_valid` arrives DIV+5 clocks after release.

Source files
------------

// File: rtl/sound_mixer_pkg.sv
// Shared constants and FSM state type for the time-multiplexed sound mixer.
package sound_mixer_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int VOL_W      = 8;
   localparam int ACC_W      = 27;
   localparam int VOL_UNITY  = 128;
   localparam int GAIN_SHIFT = 7;
   // 16-bit signed times 8-bit unsigned always fits in 24 signed bits.
   localparam int PROD_W     = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      SAT  = 2'd2
   } mixer_state_t;

endpackage

// File: rtl/sound_mixer_tick_gen.sv
// Free-running sample-period counter; tick is high in the cycle where the count equals DIV-1.
module sample_tick_gen #(
   parameter int DIV = 896
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick  = (cnt_q == CNT_LAST);
   assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sound_mixer.sv
// Mixes up to eight signed 16-bit channels with per-channel 8-bit volume through one
// shared multiplier, producing one saturated 16-bit sample per DIV clocks.
module sound_mixer
   import sound_mixer_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DIV      = 896
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CHANNELS*SAMPLE_W-1:0] ch_in,
   input  logic                         vol_wr,
   input  logic [2:0]                   vol_addr,
   input  logic [VOL_W-1:0]             vol_data,
   output logic [SAMPLE_W-1:0]          sound_out,
   output logic                         sound_valid
);

   localparam logic [SAMPLE_W-1:0] SAT_MAX  = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] SAT_MIN  = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [2:0]          IDX_LAST = 3'(CHANNELS - 1);

   logic                        tick;
   mixer_state_t                state_q, state_d;
   logic signed [ACC_W-1:0]     acc_q, acc_d;
   logic [2:0]                  idx_q, idx_d;
   logic [SAMPLE_W-1:0]         sound_out_q, sound_out_d;
   logic                        sound_valid_q, sound_valid_d;
   logic                        snap_load;

   logic signed [SAMPLE_W-1:0]  ch_arr     [CHANNELS];
   logic [VOL_W-1:0]            vol_q      [CHANNELS];
   logic signed [SAMPLE_W-1:0]  snap_ch_q  [CHANNELS];
   logic [VOL_W-1:0]            snap_vol_q [CHANNELS];

   logic signed [SAMPLE_W-1:0]  mul_ch;
   logic [VOL_W-1:0]            mul_vol;
   logic signed [SAMPLE_W:0]    mul_a;
   logic signed [VOL_W:0]       mul_b;
   logic signed [PROD_W-1:0]    prod;
   logic signed [ACC_W-1:0]     shifted;
   logic [ACC_W-SAMPLE_W:0]     head;
   logic [SAMPLE_W-1:0]         sat_val;

   sample_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign ch_arr[gi] = ch_in[gi*SAMPLE_W +: SAMPLE_W];
   end

   // Only in-range addresses can match a channel index, so other writes fall away.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            vol_q[i] <= VOL_W'(VOL_UNITY);
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (vol_wr && (vol_addr == 3'(i))) begin
               vol_q[i] <= vol_data;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            snap_ch_q[i]  <= '0;
            snap_vol_q[i] <= '0;
         end
      end else if (snap_load) begin
         for (int i = 0; i < CHANNELS; i++) begin
            snap_ch_q[i]  <= ch_arr[i];
            snap_vol_q[i] <= vol_q[i];
         end
      end
   end

   always_comb begin
      mul_ch  = '0;
      mul_vol = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (idx_q == 3'(i)) begin
            mul_ch  = snap_ch_q[i];
            mul_vol = snap_vol_q[i];
         end
      end
   end

   // Volume is zero-extended so the signed multiply treats it as unsigned.
   assign mul_a = {mul_ch[SAMPLE_W-1], mul_ch};
   assign mul_b = {1'b0, mul_vol};
   assign prod  = PROD_W'(mul_a) * PROD_W'(mul_b);

   assign shifted = acc_q >>> GAIN_SHIFT;
   assign head    = shifted[ACC_W-1:SAMPLE_W-1];

   always_comb begin
      if ((head == '0) || (head == '1)) begin
         sat_val = shifted[SAMPLE_W-1:0];
      end else if (shifted[ACC_W-1]) begin
         sat_val = SAT_MIN;
      end else begin
         sat_val = SAT_MAX;
      end
   end

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      idx_d         = idx_q;
      sound_out_d   = sound_out_q;
      sound_valid_d = 1'b0;
      snap_load     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d   = MAC;
               acc_d     = '0;
               idx_d     = '0;
               snap_load = 1'b1;
            end
         end
         MAC: begin
            acc_d = acc_q + ACC_W'(prod);
            idx_d = idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
               state_d = SAT;
            end
         end
         SAT: begin
            sound_out_d   = sat_val;
            sound_valid_d = 1'b1;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         idx_q         <= '0;
         sound_out_q   <= '0;
         sound_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         idx_q         <= idx_d;
         sound_out_q   <= sound_out_d;
         sound_valid_q <= sound_valid_d;
      end
   end

   assign sound_out   = sound_out_q;
   assign sound_valid = sound_valid_q;

endmodule
